// File: rtl/pgm_gfx_pkg.sv
// rtl/pgm_gfx_pkg.sv - shared types and constants for the graphics-ROM cache port
package pgm_gfx_pkg;

    localparam int         LINE_WORDS = 4;
    localparam logic [7:0] BURST_LEN  = 8'd4;
    localparam int         GFX_ADDR_W = 29;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_FILL,
        RESP,
        WAIT_DROP
    } state_e;

endpackage

// File: rtl/pgm_gfx_cache_ram.sv
// rtl/pgm_gfx_cache_ram.sv - simple dual-port RAM with one-cycle registered read
module pgm_gfx_cache_ram #(
    parameter int WIDTH     = 64,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [WIDTH-1:0]     rdata_o
);

    logic [WIDTH-1:0] mem_q [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/pgm_gfx_rom_port.sv
// rtl/pgm_gfx_rom_port.sv - direct-mapped line cache between renderer ROM reads and DDRAM (PGM_GFX_CACHE_STATS_EN adds hit/miss counters)
module pgm_gfx_rom_port
    import pgm_gfx_pkg::*;
#(
    parameter int INDEX_BITS = 8,
    parameter int ADDR_W     = GFX_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inval,
    input  logic              req_rd,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_busy,
    output logic [63:0]       req_dout,
    output logic              req_dout_ready,
    input  logic              ddram_busy,
    output logic              ddram_rd,
    output logic [ADDR_W-1:0] ddram_addr,
    output logic [7:0]        ddram_burstcnt,
    input  logic [63:0]       ddram_dout,
    input  logic              ddram_dout_ready
`ifdef PGM_GFX_CACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int BEAT_W = $clog2(LINE_WORDS);
    localparam int TAG_W  = ADDR_W - INDEX_BITS - BEAT_W;
    localparam int LINES  = 1 << INDEX_BITS;

    state_e                  state_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [BEAT_W-1:0]       beat_q;
    logic                    inval_pend_q;
    logic [LINES-1:0]        valid_q;
    logic [63:0]             dout_q;
    logic                    ready_q;
    logic                    rd_q;
    logic [ADDR_W-1:0]       daddr_q;
    logic [7:0]              burst_q;

    logic [INDEX_BITS-1:0]   lat_index;
    logic [TAG_W-1:0]        lat_tag;
    logic [BEAT_W-1:0]       lat_word;
    logic [INDEX_BITS+BEAT_W-1:0] rd_sel;
    logic [63:0]             data_rdata;
    logic [TAG_W-1:0]        tag_rdata;
    logic                    fill_we;
    logic                    last_beat;
    logic                    hit;

    assign lat_word  = addr_q[BEAT_W-1:0];
    assign lat_index = addr_q[INDEX_BITS+BEAT_W-1:BEAT_W];
    assign lat_tag   = addr_q[ADDR_W-1:INDEX_BITS+BEAT_W];

    // RAMs are addressed from the live request in IDLE so the lookup data is ready in LOOKUP
    always_comb begin
        rd_sel = addr_q[INDEX_BITS+BEAT_W-1:0];
        if (state_q == IDLE) begin
            rd_sel = req_addr[INDEX_BITS+BEAT_W-1:0];
        end
    end

    assign fill_we   = !reset && (state_q == MISS_FILL) && ddram_dout_ready;
    assign last_beat = (beat_q == BEAT_W'(LINE_WORDS - 1));
    assign hit       = valid_q[lat_index] && (tag_rdata == lat_tag) && !inval;

    pgm_gfx_cache_ram #(
        .WIDTH     (64),
        .ADDR_BITS (INDEX_BITS + BEAT_W)
    ) u_data_ram (
        .clk     (clk),
        .we_i    (fill_we),
        .waddr_i ({lat_index, beat_q}),
        .wdata_i (ddram_dout),
        .raddr_i (rd_sel),
        .rdata_o (data_rdata)
    );

    pgm_gfx_cache_ram #(
        .WIDTH     (TAG_W),
        .ADDR_BITS (INDEX_BITS)
    ) u_tag_ram (
        .clk     (clk),
        .we_i    (fill_we && last_beat),
        .waddr_i (lat_index),
        .wdata_i (lat_tag),
        .raddr_i (rd_sel[INDEX_BITS+BEAT_W-1:BEAT_W]),
        .rdata_o (tag_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            beat_q       <= '0;
            inval_pend_q <= 1'b0;
            valid_q      <= '0;
            dout_q       <= '0;
            ready_q      <= 1'b0;
            rd_q         <= 1'b0;
            daddr_q      <= '0;
            burst_q      <= '0;
        end else begin
            burst_q <= BURST_LEN;
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_rd) begin
                        addr_q  <= req_addr;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        dout_q  <= data_rdata;
                        ready_q <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        rd_q         <= 1'b1;
                        daddr_q      <= {lat_tag, lat_index, {BEAT_W{1'b0}}};
                        beat_q       <= '0;
                        inval_pend_q <= 1'b0;
                        state_q      <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (!ddram_busy) begin
                        rd_q    <= 1'b0;
                        state_q <= MISS_FILL;
                    end
                end
                MISS_FILL: begin
                    if (ddram_dout_ready) begin
                        beat_q <= beat_q + BEAT_W'(1);
                        if (beat_q == lat_word) begin
                            dout_q <= ddram_dout;
                        end
                        if (last_beat) begin
                            // an inval seen during the miss leaves the freshly filled line invalid
                            if (!inval_pend_q && !inval) begin
                                valid_q[lat_index] <= 1'b1;
                            end
                            ready_q <= 1'b1;
                            state_q <= RESP;
                        end
                    end
                end
                RESP: begin
                    state_q <= WAIT_DROP;
                end
                WAIT_DROP: begin
                    if (!req_rd) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
            if (inval) begin
                valid_q <= '0;
                if (state_q == MISS_REQ || state_q == MISS_FILL) begin
                    inval_pend_q <= 1'b1;
                end
            end
        end
    end

    assign req_busy       = (state_q != IDLE);
    assign req_dout       = dout_q;
    assign req_dout_ready = ready_q;
    assign ddram_rd       = rd_q;
    assign ddram_addr     = daddr_q;
    assign ddram_burstcnt = burst_q;

`ifdef PGM_GFX_CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == LOOKUP) begin
            if (hit) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) begin
                    hit_cnt_q <= hit_cnt_q + 32'd1;
                end
            end else begin
                if (miss_cnt_q != 32'hFFFF_FFFF) begin
                    miss_cnt_q <= miss_cnt_q + 32'd1;
                end
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_pgm_gfx_rom_port.sv
// tb/tb_pgm_gfx_rom_port.sv - randomized self-checking bench for pgm_gfx_rom_port
module tb_pgm_gfx_rom_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        inval;
    logic        req_rd;
    logic [28:0] req_addr;
    logic        req_busy;
    logic [63:0] req_dout;
    logic        req_dout_ready;
    logic        ddram_busy;
    logic        ddram_rd;
    logic [28:0] ddram_addr;
    logic [7:0]  ddram_burstcnt;
    logic [63:0] ddram_dout;
    logic        ddram_dout_ready;
`ifdef PGM_GFX_CACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    bit          model_valid [256];
    logic [18:0] model_tag   [256];
    int          model_hits;
    int          model_misses;

    always #5 clk = ~clk;

    pgm_gfx_rom_port dut (
        .clk              (clk),
        .reset            (reset),
        .inval            (inval),
        .req_rd           (req_rd),
        .req_addr         (req_addr),
        .req_busy         (req_busy),
        .req_dout         (req_dout),
        .req_dout_ready   (req_dout_ready),
        .ddram_busy       (ddram_busy),
        .ddram_rd         (ddram_rd),
        .ddram_addr       (ddram_addr),
        .ddram_burstcnt   (ddram_burstcnt),
        .ddram_dout       (ddram_dout),
        .ddram_dout_ready (ddram_dout_ready)
`ifdef PGM_GFX_CACHE_STATS_EN
        ,
        .hit_cnt          (hit_cnt),
        .miss_cnt         (miss_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rom_word(input logic [28:0] a);
        return (64'(a) * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    task automatic model_clear();
        foreach (model_valid[i]) model_valid[i] = 1'b0;
    endtask

    task automatic check_stats();
`ifdef PGM_GFX_CACHE_STATS_EN
        check_eq("hit_cnt", 64'(hit_cnt), 64'(model_hits));
        check_eq("miss_cnt", 64'(miss_cnt), 64'(model_misses));
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; inval = 1'b0; req_rd = 1'b0; ddram_busy = 1'b0; ddram_dout_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_busy", 64'(req_busy), 64'd0);
        check_eq("rst_ready", 64'(req_dout_ready), 64'd0);
        check_eq("rst_dout", req_dout, 64'd0);
        check_eq("rst_ddram_rd", 64'(ddram_rd), 64'd0);
        check_eq("rst_ddram_addr", 64'(ddram_addr), 64'd0);
        check_eq("rst_burstcnt", 64'(ddram_burstcnt), 64'd0);
        reset = 1'b0;
        model_clear();
        model_hits = 0;
        model_misses = 0;
        check_stats();
        @(negedge clk);
        check_eq("burstcnt_after_rst", 64'(ddram_burstcnt), 64'd4);
    endtask

    task automatic do_inval();
        @(negedge clk);
        inval = 1'b1;
        @(negedge clk);
        inval = 1'b0;
        model_clear();
    endtask

    // One renderer read with a cycle-by-cycle DDRAM responder; inval_beat < 0 means no inval
    task automatic do_read(input logic [28:0] a, input int busy_n, input int inval_beat);
        int          idx = int'(a[9:2]);
        logic [18:0] tg = a[28:10];
        bit          exp_hit;
        int          rd_cycles = 0, cmds = 0, ready_cnt = 0, ready_at = 0;
        int          beats = 0, gap = 0, hold = 0, busy_left = busy_n;
        bit          accepted = 0, dropped = 0, done = 0, inval_used = 0, addr_moved = 0;
        logic [63:0] got = 'x;
        logic [28:0] cmd_addr = '0;

        exp_hit = model_valid[idx] && (model_tag[idx] == tg);
        @(negedge clk);
        req_rd = 1'b1;
        req_addr = a;
        for (int c = 1; c <= 300 && !done; c++) begin
            @(negedge clk);
            ddram_dout_ready = 1'b0;
            inval = 1'b0;
            if (req_dout_ready) begin
                ready_cnt++;
                got = req_dout;
                if (ready_at == 0) ready_at = c;
                hold = $urandom_range(0, 3);
            end
            if (dropped && !req_busy) begin
                done = 1;
            end else begin
                req_addr = 29'($urandom);
                ddram_dout = {$urandom, $urandom};
                if (ddram_rd) begin
                    if (rd_cycles == 0) cmd_addr = ddram_addr;
                    else if (ddram_addr !== cmd_addr) addr_moved = 1;
                    rd_cycles++;
                    if (busy_left > 0) begin
                        ddram_busy = 1'b1;
                        busy_left--;
                    end else begin
                        ddram_busy = 1'b0;
                        accepted = 1;
                        cmds++;
                    end
                end else begin
                    ddram_busy = 1'($urandom_range(0, 1));
                    if (accepted && beats < 4) begin
                        if (gap > 0) begin
                            gap--;
                        end else begin
                            ddram_dout_ready = 1'b1;
                            ddram_dout = rom_word(cmd_addr + 29'(beats));
                            if (beats == inval_beat) begin
                                inval = 1'b1;
                                inval_used = 1;
                            end
                            beats++;
                            gap = $urandom_range(0, 2);
                        end
                    end else if ((!accepted || beats == 4) && $urandom_range(0, 7) == 0) begin
                        ddram_dout_ready = 1'b1;
                    end
                end
                if (ready_cnt > 0 && !dropped) begin
                    if (hold == 0) begin
                        req_rd = 1'b0;
                        dropped = 1;
                    end else begin
                        hold--;
                    end
                end
            end
        end
        ddram_busy = 1'b0;
        ddram_dout_ready = 1'b0;
        inval = 1'b0;
        req_rd = 1'b0;

        check_eq("read_done", 64'(done), 64'd1);
        check_eq("rdata", got, rom_word(a));
        check_eq("ready_pulses", 64'(ready_cnt), 64'd1);
        check_eq("ddram_cmds", 64'(cmds), exp_hit ? 64'd0 : 64'd1);
        check_eq("burstcnt", 64'(ddram_burstcnt), 64'd4);
        if (exp_hit) begin
            check_eq("hit_latency", 64'(ready_at), 64'd2);
            model_hits++;
        end else begin
            check_eq("cmd_addr", 64'(cmd_addr), 64'({a[28:2], 2'b00}));
            check_eq("rd_len", 64'(rd_cycles), 64'(busy_n + 1));
            check_eq("cmd_stable", 64'(addr_moved), 64'd0);
            model_misses++;
            if (inval_used) begin
                model_clear();
            end else begin
                model_valid[idx] = 1'b1;
                model_tag[idx] = tg;
            end
        end
        check_stats();
    endtask

    initial begin
        reset = 1'b1; inval = 1'b0; req_rd = 1'b0; req_addr = '0;
        ddram_busy = 1'b0; ddram_dout = '0; ddram_dout_ready = 1'b0;
        model_hits = 0; model_misses = 0;
        model_clear();
        do_reset();

        do_read(29'h0000105, 0, -1);
        do_read(29'h0000107, 0, -1);
        do_read(29'h0000106, 0, -1);
        do_read(29'h0000504, 0, -1);
        do_read(29'h0000105, 0, -1);
        do_read(29'h0000504, 5, -1);
        do_read(29'h0000508, 0, 2);
        do_read(29'h0000508, 0, -1);
        do_read(29'h000050B, 0, -1);
        do_inval();
        do_read(29'h000050A, 2, -1);
        do_read(29'h1FFFFFFF, 1, -1);
        do_read(29'h1FFFFFFC, 0, -1);

        for (int n = 0; n < 160; n++) begin
            logic [18:0] rt;
            logic [7:0]  ri;
            rt = 19'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) rt[18] = 1'b1;
            ri = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) ri = 8'hFF;
            do_read({rt, ri, 2'($urandom_range(0, 3))}, $urandom_range(0, 3),
                    ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1);
            if ($urandom_range(0, 19) == 0) do_inval();
        end

        do_reset();
        do_read(29'h0000105, 0, -1);
        do_read(29'h0000104, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
